// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One shared (n+1)-bit add/subtract unit is stepped once per RUN cycle.
module mdu_seq #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         mthi,
    input  logic         mtlo,
    input  logic [n-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         dz,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_r;
    logic            sa;
    logic            sb;
    logic [n-1:0]    a_orig;
    logic [n-1:0]    m;      // multiplicand or divisor (magnitude)
    logic [n-1:0]    acc;    // upper partial product or partial remainder
    logic [n-1:0]    mq;     // multiplier / quotient shift register

    logic [n:0]      au_x;
    logic [n:0]      au_y;
    logic [n:0]      au_r;
    logic            au_sub;
    logic [n:0]      mul_sel;
    logic [2*n-1:0]  prod;
    logic [n-1:0]    quot;
    logic [n-1:0]    rem;
    logic [n-1:0]    abs_a;
    logic [n-1:0]    abs_b;

    function automatic logic [n-1:0] neg_n(input logic [n-1:0] x);
        return ~x + {{(n-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*n-1:0] neg_2n(input logic [2*n-1:0] x);
        return ~x + {{(2*n-1){1'b0}}, 1'b1};
    endfunction

    // Divide shifts the next dividend bit into the remainder before the trial subtract.
    always_comb begin
        au_sub = op_r[1];
        au_y   = {1'b0, m};
        if (op_r[1]) begin
            au_x = {acc, mq[n-1]};
        end else begin
            au_x = {1'b0, acc};
        end
    end

    assign au_r = au_x + (au_sub ? ~au_y : au_y) + {{n{1'b0}}, au_sub};

    always_comb begin
        mul_sel = mq[0] ? au_r : {1'b0, acc};
        abs_a   = (!op[0] && a[n-1]) ? neg_n(a) : a;
        abs_b   = (!op[0] && b[n-1]) ? neg_n(b) : b;
        prod    = {acc, mq};
        quot    = mq;
        rem     = acc;
        if (!op_r[0]) begin
            if (sa ^ sb) begin
                prod = neg_2n({acc, mq});
                quot = neg_n(mq);
            end
            if (sa) begin
                rem = neg_n(acc);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        sa     <= a[n-1];
                        sb     <= b[n-1];
                        a_orig <= a;
                        acc    <= '0;
                        mq     <= op[1] ? abs_a : abs_b;
                        m      <= op[1] ? abs_b : abs_a;
                        cnt    <= CW'(n);
                        dz     <= op[1] & (b == '0);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    if (op_r[1]) begin
                        // Restoring divide: a negative trial result keeps the old remainder.
                        if (au_r[n]) begin
                            acc <= au_x[n-1:0];
                            mq  <= {mq[n-2:0], 1'b0};
                        end else begin
                            acc <= au_r[n-1:0];
                            mq  <= {mq[n-2:0], 1'b1};
                        end
                    end else begin
                        acc <= mul_sel[n:1];
                        mq  <= {mul_sel[0], mq[n-1:1]};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz) begin
                        hi <= a_orig;
                        lo <= '1;
                    end else if (op_r[1]) begin
                        hi <= rem;
                        lo <= quot;
                    end else begin
                        hi <= prod[2*n-1:n];
                        lo <= prod[n-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
